// File: rtl/display_convert_seq_pkg.sv
// rtl/display_convert_seq_pkg.sv - shared encodings and constants for the result display converter
package display_convert_seq_pkg;

   // Conversion sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Display base selector values as driven on sel
   localparam logic [1:0] SEL_OCT   = 2'b00;
   localparam logic [1:0] SEL_HEX   = 2'b01;
   localparam logic [1:0] SEL_DEC   = 2'b10;
   localparam logic [1:0] SEL_BLANK = 2'b11;

   // All segments dark in the board's active-low sense
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // One double-dabble iteration per input bit
   localparam logic [3:0] DEC_ITERATIONS = 4'd8;

   // Active-low {g,f,e,d,c,b,a} patterns; index 15 is leftmost so SEG_TABLE[d] is digit d
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   // Double-dabble correction: a BCD nibble of 5 or more would overflow past 9 when doubled
   function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
      return (nib >= 4'd5) ? (nib + 4'd3) : nib;
   endfunction

endpackage

// File: rtl/display_convert_seq_if.sv
// rtl/display_convert_seq_if.sv - request and display bundle between the ULA and the result displays
interface display_convert_seq_if;

   logic       start;
   logic [7:0] bin;
   logic [1:0] sel;
   logic       busy;
   logic       done;
   logic [6:0] HEX0;
   logic [6:0] HEX1;
   logic [6:0] HEX2;

   // Requester side: issues conversions and watches the displays
   modport master (
      output start, bin, sel,
      input  busy, done, HEX0, HEX1, HEX2
   );

   // Converter side
   modport slave (
      input  start, bin, sel,
      output busy, done, HEX0, HEX1, HEX2
   );

endinterface

// File: rtl/display_convert_seq_seg7_digit_encoder.sv
// rtl/display_convert_seq_seg7_digit_encoder.sv - one 7-segment digit encoder with blanking
module seg7_digit_encoder
   import display_convert_seq_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   logic [6:0] w_seg_low;

   // Look up the active-low pattern, overriding with dark segments when blanked
   always_comb begin
      w_seg_low = SEG_TABLE[i_digit];
      if (i_blank) begin
         w_seg_low = SEG_BLANK;
      end
   end

   // Boards with active-high segments get every bit inverted
   assign o_seg = SEG_ACTIVE_LOW ? w_seg_low : ~w_seg_low;

endmodule

// File: rtl/display_convert_seq.sv
// rtl/display_convert_seq.sv - sequential binary to octal/hex/decimal 7-segment result stage
module display_convert_seq
   import display_convert_seq_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_HEX_MSD  = 1'b1
) (
   input  logic                 CLOCK_50,
   input  logic                 reset_debounced,
   display_convert_seq_if.slave bus
);

   state_t      r_state;
   state_t      w_state_next;

   logic [7:0]  r_shift;
   logic [11:0] r_bcd;
   logic [3:0]  r_iter;
   logic [1:0]  r_sel_q;

   logic [3:0]  r_dig0;
   logic [3:0]  r_dig1;
   logic [3:0]  r_dig2;
   logic [2:0]  r_blank;
   logic        r_done;

   logic        w_accept;
   logic        w_iter_last;
   logic [11:0] w_bcd_adj;
   logic [11:0] w_direct;
   logic [2:0]  w_blank_mask;

   // A start only counts while idle; requests during a conversion are dropped
   assign w_accept    = (r_state == ST_IDLE) && bus.start;
   assign w_iter_last = (r_iter == (DEC_ITERATIONS - 4'd1));

   // All three nibbles are corrected in parallel before the shift
   assign w_bcd_adj = {bcd_add3(r_bcd[11:8]), bcd_add3(r_bcd[7:4]), bcd_add3(r_bcd[3:0])};

   // Octal and hex digits are plain bit slices of the captured value
   always_comb begin
      w_direct = 12'h000;
      case (r_sel_q)
         SEL_OCT: w_direct = {2'b00, r_shift[7:6], 1'b0, r_shift[5:3], 1'b0, r_shift[2:0]};
         SEL_HEX: w_direct = {4'h0, r_shift[7:4], r_shift[3:0]};
         default: w_direct = 12'h000;
      endcase
   end

   // Which displays go dark for the captured base
   always_comb begin
      w_blank_mask = 3'b000;
      case (r_sel_q)
         SEL_BLANK: w_blank_mask = 3'b111;
         SEL_HEX:   w_blank_mask = {BLANK_HEX_MSD, 2'b00};
         default:   w_blank_mask = 3'b000;
      endcase
   end

   // State register
   always_ff @(posedge CLOCK_50 or negedge reset_debounced) begin
      if (!reset_debounced) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: decimal spends eight edges in CONV, every other base just one
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_next = ST_CONV;
            end
         end
         ST_CONV: begin
            if ((r_sel_q != SEL_DEC) || w_iter_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Capture on accept, then run the shift-add-3 loop or the direct slice in CONV
   always_ff @(posedge CLOCK_50 or negedge reset_debounced) begin
      if (!reset_debounced) begin
         r_shift <= 8'h00;
         r_bcd   <= 12'h000;
         r_iter  <= 4'd0;
         r_sel_q <= SEL_OCT;
      end else if (w_accept) begin
         r_shift <= bus.bin;
         r_sel_q <= bus.sel;
         r_bcd   <= 12'h000;
         r_iter  <= 4'd0;
      end else if (r_state == ST_CONV) begin
         if (r_sel_q == SEL_DEC) begin
            {r_bcd, r_shift} <= {w_bcd_adj[10:0], r_shift, 1'b0};
            r_iter           <= r_iter + 4'd1;
         end else begin
            r_bcd <= w_direct;
         end
      end
   end

   // Displayed digits only move at the DONE edge, so partial results never show
   always_ff @(posedge CLOCK_50 or negedge reset_debounced) begin
      if (!reset_debounced) begin
         r_dig0  <= 4'd0;
         r_dig1  <= 4'd0;
         r_dig2  <= 4'd0;
         r_blank <= 3'b000;
         r_done  <= 1'b0;
      end else begin
         r_done <= (r_state == ST_DONE);
         if (r_state == ST_DONE) begin
            r_dig0  <= r_bcd[3:0];
            r_dig1  <= r_bcd[7:4];
            r_dig2  <= r_bcd[11:8];
            r_blank <= w_blank_mask;
         end
      end
   end

   seg7_digit_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc0 (
      .i_digit (r_dig0),
      .i_blank (r_blank[0]),
      .o_seg   (bus.HEX0)
   );

   seg7_digit_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc1 (
      .i_digit (r_dig1),
      .i_blank (r_blank[1]),
      .o_seg   (bus.HEX1)
   );

   seg7_digit_encoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc2 (
      .i_digit (r_dig2),
      .i_blank (r_blank[2]),
      .o_seg   (bus.HEX2)
   );

   assign bus.busy = (r_state != ST_IDLE);
   assign bus.done = r_done;

endmodule

// File: tb/tb_display_convert_seq.sv
// tb/tb_display_convert_seq.sv - randomized self-checking bench for display_convert_seq
module tb_display_convert_seq;

   localparam logic [1:0] B_OCT   = 2'b00;
   localparam logic [1:0] B_HEX   = 2'b01;
   localparam logic [1:0] B_DEC   = 2'b10;
   localparam logic [1:0] B_BLANK = 2'b11;

   logic CLOCK_50;
   logic reset_debounced;
   int   n_checks;
   int   n_fail;
   logic [20:0] exp_disp;

   display_convert_seq_if bus ();

   display_convert_seq dut (
      .CLOCK_50        (CLOCK_50),
      .reset_debounced (reset_debounced),
      .bus             (bus)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Active-low segment pattern for a digit; negative means dark
   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0:  return 7'b1000000;
         1:  return 7'b1111001;
         2:  return 7'b0100100;
         3:  return 7'b0110000;
         4:  return 7'b0011001;
         5:  return 7'b0010010;
         6:  return 7'b0000010;
         7:  return 7'b1111000;
         8:  return 7'b0000000;
         9:  return 7'b0010000;
         10: return 7'b0001000;
         11: return 7'b0000011;
         12: return 7'b1000110;
         13: return 7'b0100001;
         14: return 7'b0000110;
         15: return 7'b0001110;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected {HEX2,HEX1,HEX0} from the value and base by plain arithmetic
   function automatic logic [20:0] model(input int v, input logic [1:0] s);
      int h, t, u;
      case (s)
         B_DEC: begin h = v / 100; t = (v / 10) % 10; u = v % 10; end
         B_OCT: begin h = v / 64;  t = (v / 8) % 8;   u = v % 8;  end
         B_HEX: begin h = -1;      t = v / 16;        u = v % 16; end
         default: begin h = -1; t = -1; u = -1; end
      endcase
      return {seg_ref(h), seg_ref(t), seg_ref(u)};
   endfunction

   function automatic logic [20:0] disp();
      return {bus.HEX2, bus.HEX1, bus.HEX0};
   endfunction

   // One conversion; inj >= 0 fires an extra start (other bin/sel) while the converter is busy
   task automatic run_conv(input logic [7:0] v, input logic [1:0] s, input int inj);
      int          lat;
      int          k;
      bit          seen;
      logic [20:0] want;
      lat  = (s == B_DEC) ? 9 : 2;
      want = model(int'(v), s);
      @(negedge CLOCK_50);
      bus.start = 1'b1;
      bus.bin   = v;
      bus.sel   = s;
      @(negedge CLOCK_50);
      bus.start = 1'b0;
      bus.bin   = ~v;
      bus.sel   = ~s;
      check_eq("busy_after_start", {31'd0, bus.busy}, 32'd1);
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         if (k == inj) begin
            bus.start = 1'b1;
            bus.bin   = 8'd5;
            bus.sel   = s ^ 2'b01;
         end
         @(negedge CLOCK_50);
         k++;
         bus.start = 1'b0;
         if (bus.done) begin
            seen = 1'b1;
         end else if (k == lat - 1) begin
            check_eq("held_until_done", {11'd0, disp()}, {11'd0, exp_disp});
            check_eq("busy_mid", {31'd0, bus.busy}, 32'd1);
         end
      end
      check_eq("done_seen", {31'd0, seen}, 32'd1);
      check_eq("latency", k, lat);
      check_eq("busy_at_done", {31'd0, bus.busy}, 32'd0);
      check_eq("digits", {11'd0, disp()}, {11'd0, want});
      exp_disp = want;
      @(negedge CLOCK_50);
      check_eq("done_single", {31'd0, bus.done}, 32'd0);
      check_eq("busy_after", {31'd0, bus.busy}, 32'd0);
      check_eq("digits_held", {11'd0, disp()}, {11'd0, want});
   endtask

   // Start a decimal conversion and pull reset after `when` edges
   task automatic reset_abort(input logic [7:0] v, input int when);
      bit any_done;
      @(negedge CLOCK_50);
      bus.start = 1'b1;
      bus.bin   = v;
      bus.sel   = B_DEC;
      @(negedge CLOCK_50);
      bus.start = 1'b0;
      repeat (when - 1) @(negedge CLOCK_50);
      reset_debounced = 1'b0;
      #1;
      exp_disp = {3{7'b1000000}};
      check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("abort_done", {31'd0, bus.done}, 32'd0);
      check_eq("abort_disp", {11'd0, disp()}, {11'd0, exp_disp});
      repeat (2) @(negedge CLOCK_50);
      reset_debounced = 1'b1;
      any_done = 1'b0;
      repeat (12) begin
         @(negedge CLOCK_50);
         if (bus.done) any_done = 1'b1;
      end
      check_eq("abort_no_done", {31'd0, any_done}, 32'd0);
      check_eq("abort_disp_after", {11'd0, disp()}, {11'd0, exp_disp});
   endtask

   initial begin
      logic [1:0] rs;
      int         rinj;
      n_checks        = 0;
      n_fail          = 0;
      reset_debounced = 1'b0;
      bus.start       = 1'b0;
      bus.bin         = 8'h00;
      bus.sel         = 2'b00;
      exp_disp        = {3{7'b1000000}};
      repeat (3) @(negedge CLOCK_50);
      check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("reset_done", {31'd0, bus.done}, 32'd0);
      check_eq("reset_disp", {11'd0, disp()}, {11'd0, exp_disp});
      reset_debounced = 1'b1;

      run_conv(8'd255, B_DEC, -1);
      run_conv(8'hAF,  B_HEX, -1);
      run_conv(8'd255, B_OCT, -1);
      run_conv(8'd0,   B_DEC, -1);
      run_conv(8'd100, B_DEC, -1);
      run_conv(8'd7,   B_DEC, -1);
      run_conv(8'd128, B_DEC, 2);
      reset_abort(8'd200, 4);
      run_conv(8'd200, B_DEC, -1);
      run_conv(8'h5A,  B_BLANK, -1);

      repeat (10) begin
         @(negedge CLOCK_50);
         bus.bin = 8'($urandom);
         bus.sel = 2'($urandom);
      end
      @(negedge CLOCK_50);
      check_eq("idle_hold_disp", {11'd0, disp()}, {11'd0, exp_disp});
      check_eq("idle_hold_done", {31'd0, bus.done}, 32'd0);

      repeat (40) begin
         rs   = 2'($urandom);
         rinj = -1;
         if ($urandom_range(0, 1) == 1) begin
            rinj = int'($urandom_range(0, (rs == B_DEC) ? 8 : 1));
         end
         run_conv(8'($urandom), rs, rinj);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_convert_seq.md
Name: display_convert_seq

Overview:
- Sequential downstream stage between the ULA result register and the three 7-segment result displays (HEX2..HEX0).
- On a start pulse it captures an 8-bit result and a display-base selector.
- Decimal conversion uses an iterative shift-add-3 (double-dabble) over 8 cycles; octal and hex use direct slicing.
- Converted digits are encoded to segments and held stable until the next conversion completes.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment lit by 0 (board default); 0 = inverts all segment outputs.
- BLANK_HEX_MSD, 1, 1 = hundreds display blanked in hex mode; 0 = shows "0".

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset_debounced  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; driven by the ULA result-load enable.
- bin  input  8  unsigned value to display; sampled only on an accepted start.
- sel  input  2  base: 00 octal, 01 hex, 10 decimal, 11 blank.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are on the outputs.
- HEX0  output  7  units display, segments {g,f,e,d,c,b,a}.
- HEX1  output  7  tens display.
- HEX2  output  7  hundreds display.

Behaviour:
- Clock and reset: clock CLOCK_50; reset reset_debounced, asynchronous, active-low.
- Reset values: state IDLE, busy=0, done=0, digit registers 0, HEX2..HEX0 show "000" (7'b1000000 each when active-low). Reset asserted mid-conversion aborts immediately; no partial digits are ever output.
- States: IDLE, CONV, DONE.
- IDLE, start=1 at edge E0: capture bin into the shift register and sel into sel_q; clear the BCD accumulator and iteration counter; go to CONV; busy=1 from E0.
- CONV, decimal (sel_q=10): one iteration per edge, E1..E8.
  - Each BCD nibble >=5 gets +3 (before the shift, all nibbles in parallel).
  - Then {bcd[11:0],shift} shifts left 1.
  - After E8 the counter reaches 8 and the next state is DONE.
- CONV, octal/hex/blank: single edge E1.
  - Octal digits = {bin[7:6]}, bin[5:3], bin[2:0].
  - Hex digits = 0, bin[7:4], bin[3:0].
  - Next state is DONE.
- DONE, one edge (E9 decimal, E2 other modes):
  - Load the output digit registers and the blank mask.
  - done=1 for exactly the following cycle; busy=0.
  - Return to IDLE.
- Latency from accepted start edge to done high: 9 cycles (decimal), 2 cycles (octal/hex/blank).
- start while busy (CONV or DONE): ignored, not queued.
- Changes on bin or sel after capture have no effect until the next accepted start.
- Outputs change only at the DONE edge; between conversions HEX2..HEX0 are held.
- Blank (sel=11): all three displays 7'b1111111.
- Hex mode with BLANK_HEX_MSD=1: HEX2 blank.
- No leading-zero suppression in any other case (decimal 7 shows "007").
- Digit range: decimal hundreds <=2; octal hundreds <=3. Hex A–F are encoded as A, b, C, d, E, F.
- Segment map (active-low, before the SEG_ACTIVE_LOW inversion):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Shared package holds:
  - state encoding (IDLE, CONV, DONE)
  - base constants SEL_OCT, SEL_HEX, SEL_DEC, SEL_BLANK
  - SEG_BLANK
  - the 16-entry segment constant table
  - DEC_ITERATIONS=8
- One natural sub-module: seg7_digit_encoder (combinational; 4-bit digit + blank in, 7-bit segments out), instantiated three times.

Test Plan:
- Reset, then sel=10, bin=255, start pulse -> busy 9 cycles; done at cycle 9; HEX2/1/0 = 2,5,5 (0100100, 0010010, 0010010).
- sel=01, bin=0xAF, start -> done after 2 cycles; HEX2 blank (1111111), HEX1 = A (0001000), HEX0 = F (0001110).
- sel=00, bin=255 -> 3,7,7. Then sel=10, bin=0 -> 0,0,0. Then bin=100 -> 1,0,0.
- During a decimal conversion of 128: pulse start with bin=5 at cycle 3 and toggle sel -> ignored; result 1,2,8; done exactly once.
- Assert reset at cycle 4 of a decimal conversion of 200 -> busy=0 immediately; displays "000"; no done pulse. A new start afterwards converts correctly.
- sel=11, start -> all three displays 1111111 after 2 cycles. With no start, bin changes leave the displays unchanged.
